// File: rtl/alu_operation_sequencer.sv
// Sequences one ALU operation per request: IDLE -> ISSUE (single WF pulse) -> CAPTURE -> DONE.
// Result valid two edges after accept; DONE holds it until RspReady, and new requests stall meanwhile.
module alu_operation_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [31:0]      ReqA,
   input  logic [31:0]      ReqB,
   input  logic [4:0]       ReqFunSel,
   input  logic             ReqWF,
   output logic [31:0]      A,
   output logic [31:0]      B,
   output logic [4:0]       FunSel,
   output logic             WF,
   input  logic [31:0]      ALUOut,
   input  logic [3:0]       FlagsOut,
   output logic             RspValid,
   input  logic             RspReady,
   output logic [31:0]      RspData,
   output logic [3:0]       RspFlags,
   output logic             Busy,
   output logic [CNT_W-1:0] OpCount
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

   state_t state;
   state_t nextState;
   logic   outOfReset;
   logic   wfHold;
   logic   accept;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // outOfReset keeps ReqReady low until the first edge after reset release
   always_comb begin
      nextState = state;
      ReqReady  = 1'b0;
      WF        = 1'b0;
      RspValid  = 1'b0;
      Busy      = 1'b1;
      case (state)
         IDLE: begin
            Busy     = 1'b0;
            ReqReady = outOfReset;
            if (outOfReset && ReqValid) nextState = ISSUE;
         end
         ISSUE: begin
            WF        = wfHold;
            nextState = CAPTURE;
         end
         CAPTURE: nextState = DONE;
         DONE: begin
            RspValid = 1'b1;
            if (RspReady) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   assign accept = ReqReady & ReqValid;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         outOfReset <= 1'b0;
         wfHold     <= 1'b0;
         A          <= '0;
         B          <= '0;
         FunSel     <= '0;
         RspData    <= '0;
         RspFlags   <= '0;
         OpCount    <= '0;
      end else begin
         outOfReset <= 1'b1;
         if (accept) begin
            A      <= ReqA;
            B      <= ReqB;
            FunSel <= ReqFunSel;
            wfHold <= ReqWF;
         end
         // ALU flags were written on the ISSUE edge, so FlagsOut here is post-update
         if (state == CAPTURE) begin
            RspData  <= ALUOut;
            RspFlags <= FlagsOut;
         end
         if (state == DONE && RspReady) begin
            OpCount <= OpCount + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_alu_operation_sequencer.sv
// Bench for alu_operation_sequencer with a behavioural ADD/ADC ALU and a result scoreboard.
`timescale 1ns/1ps
module tb_alu_operation_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        ReqValid, ReqReady, ReqWF, WF, RspValid, RspReady, Busy;
   logic [31:0] ReqA, ReqB, A, B, ALUOut, RspData;
   logic [4:0]  ReqFunSel, FunSel;
   logic [3:0]  FlagsOut, RspFlags;
   logic [15:0] OpCount;

   logic        sReqValid, sReqReady, sWF, sRspValid, sRspReady, sBusy;
   logic [31:0] sReqA, sReqB, sA, sB, sRspData;
   logic [4:0]  sFunSel;
   logic [3:0]  sRspFlags;
   logic [2:0]  sOpCount;

   int errors = 0;
   int checks = 0;
   int expCount = 0;

   logic [3:0]  aluFlags;
   logic        presetVld;
   logic [3:0]  presetVal;
   logic [35:0] aluRes;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  flags;
   } exp_t;
   exp_t expQ[$];

   always #5 Clock = ~Clock;

   alu_operation_sequencer #(.CNT_W(16)) dut (
      .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqA(ReqA), .ReqB(ReqB), .ReqFunSel(ReqFunSel), .ReqWF(ReqWF),
      .A(A), .B(B), .FunSel(FunSel), .WF(WF), .ALUOut(ALUOut), .FlagsOut(FlagsOut),
      .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspFlags(RspFlags),
      .Busy(Busy), .OpCount(OpCount)
   );

   alu_operation_sequencer #(.CNT_W(3)) dutSmall (
      .Clock(Clock), .Reset(Reset), .ReqValid(sReqValid), .ReqReady(sReqReady),
      .ReqA(sReqA), .ReqB(sReqB), .ReqFunSel(5'b00001), .ReqWF(1'b0),
      .A(sA), .B(sB), .FunSel(sFunSel), .WF(sWF), .ALUOut(sA ^ sB), .FlagsOut(4'b0101),
      .RspValid(sRspValid), .RspReady(sRspReady), .RspData(sRspData), .RspFlags(sRspFlags),
      .Busy(sBusy), .OpCount(sOpCount)
   );

   // {Z,C,N,O,result}; 10101 is add-with-carry, everything else adds
   function automatic logic [35:0] aluCalc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] fs, input logic cin);
      logic [32:0] s;
      logic [31:0] r;
      s = {1'b0, a} + {1'b0, b} + {32'd0, (fs == 5'b10101) & cin};
      r = s[31:0];
      return {r == 32'd0, s[32], r[31], (a[31] == b[31]) && (r[31] != a[31]), r};
   endfunction

   assign aluRes   = aluCalc(A, B, FunSel, aluFlags[2]);
   assign ALUOut   = aluRes[31:0];
   assign FlagsOut = aluFlags;

   always @(posedge Clock) begin
      if (presetVld)  aluFlags <= presetVal;
      else if (WF)    aluFlags <= aluRes[35:32];
   end

   task automatic presetFlags(input logic [3:0] v);
      presetVal = v;
      presetVld = 1'b1;
      @(posedge Clock); #1;
      presetVld = 1'b0;
   endtask

   task automatic pushExp(input logic [31:0] d, input logic [3:0] f);
      exp_t e;
      e.data  = d;
      e.flags = f;
      expQ.push_back(e);
   endtask

   // One full transaction; called #1 after a rising edge.
   task automatic doOp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] fs,
                       input logic wf, input int stall, input string tag);
      exp_t e;
      int n;
      logic [31:0] hData;
      logic [3:0]  hFlags;
      n = 0;
      while (!ReqReady && n < 20) begin
         @(posedge Clock); #1;
         n++;
      end
      checks++;
      if (ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: ReqReady=%b want 1", tag, ReqReady);
      end
      ReqA = a; ReqB = b; ReqFunSel = fs; ReqWF = wf; ReqValid = 1'b1;
      @(posedge Clock); #1;
      ReqValid = 1'b0;
      // ISSUE
      checks++;
      if ({WF, RspValid, Busy, ReqReady} !== {wf, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL %s issue_ctl: WF,RspValid,Busy,ReqReady=%b want %b", tag,
                  {WF, RspValid, Busy, ReqReady}, {wf, 3'b010});
      end
      checks++;
      if ({A, B, FunSel} !== {a, b, fs}) begin
         errors++;
         $display("FAIL %s issue_operands: A=%h B=%h FunSel=%b want %h %h %b", tag, A, B, FunSel, a, b, fs);
      end
      @(posedge Clock); #1;
      // CAPTURE
      checks++;
      if ({WF, RspValid, Busy} !== 3'b001) begin
         errors++;
         $display("FAIL %s capture_ctl: WF,RspValid,Busy=%b want 001", tag, {WF, RspValid, Busy});
      end
      @(posedge Clock); #1;
      // DONE
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard_empty: queue size 0 want 1", tag);
         e = '0;
      end else begin
         e = expQ.pop_front();
      end
      checks++;
      if ({RspValid, WF, ReqReady} !== 3'b100) begin
         errors++;
         $display("FAIL %s done_ctl: RspValid,WF,ReqReady=%b want 100", tag, {RspValid, WF, ReqReady});
      end
      checks++;
      if (RspData !== e.data || RspFlags !== e.flags) begin
         errors++;
         $display("FAIL %s result: RspData=%h RspFlags=%b want %h %b", tag, RspData, RspFlags, e.data, e.flags);
      end
      hData  = RspData;
      hFlags = RspFlags;
      for (int i = 0; i < stall; i++) begin
         ReqValid = ~ReqValid;
         ReqA = ~a;
         @(posedge Clock); #1;
         checks++;
         if ({RspValid, ReqReady, WF} !== 3'b100 || RspData !== hData || RspFlags !== hFlags || A !== a) begin
            errors++;
            $display("FAIL %s stall%0d: RspValid,ReqReady,WF=%b RspData=%h RspFlags=%b A=%h want 100 %h %b %h",
                     tag, i, {RspValid, ReqReady, WF}, RspData, RspFlags, A, hData, hFlags, a);
         end
      end
      ReqValid = 1'b0;
      RspReady = 1'b1;
      @(posedge Clock); #1;
      RspReady = 1'b0;
      expCount++;
      checks++;
      if ({RspValid, Busy, ReqReady} !== 3'b001 || OpCount !== 16'(expCount)) begin
         errors++;
         $display("FAIL %s handoff: RspValid,Busy,ReqReady=%b OpCount=%0d want 001 %0d", tag,
                  {RspValid, Busy, ReqReady}, OpCount, expCount);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      #12;
      checks++;
      if ({A, B, FunSel, WF, RspData, RspFlags, RspValid, Busy, ReqReady, OpCount} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: A=%h B=%h FunSel=%b WF=%b RspData=%h RspFlags=%b RspValid=%b Busy=%b ReqReady=%b OpCount=%0d want all 0",
                  A, B, FunSel, WF, RspData, RspFlags, RspValid, Busy, ReqReady, OpCount);
      end
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock); #1;
      checks++;
      if (ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: ReqReady=%b want 1", ReqReady);
      end
   endtask

   task automatic test_reset_mid();
      ReqA = 32'h0000_0001; ReqB = 32'h0000_0002; ReqFunSel = 5'b10100; ReqWF = 1'b1; ReqValid = 1'b1;
      @(posedge Clock); #1;
      ReqValid = 1'b0;
      @(posedge Clock); #1;
      checks++;
      if (Busy !== 1'b1 || RspValid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_capture_state: Busy=%b RspValid=%b want 1 0", Busy, RspValid);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if ({A, B, FunSel, WF, RspData, RspFlags, RspValid, Busy, ReqReady, OpCount} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: A=%h B=%h WF=%b RspData=%h RspValid=%b Busy=%b ReqReady=%b OpCount=%0d want all 0",
                  A, B, WF, RspData, RspValid, Busy, ReqReady, OpCount);
      end
      @(posedge Clock); #1;
      @(negedge Clock);
      Reset = 1'b1;
      expCount = 0;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      checks++;
      if (RspValid !== 1'b0 || OpCount !== 16'd0 || ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL midreset_abandon: RspValid=%b OpCount=%0d ReqReady=%b want 0 0 1", RspValid, OpCount, ReqReady);
      end
   endtask

   task automatic test_add_flags();
      presetFlags(4'b1111);
      pushExp(32'h5555_5555, 4'b0000);
      doOp(32'h1234_1234, 32'h4321_4321, 5'b10100, 1'b1, 0, "add_wf");
   endtask

   task automatic test_adc();
      presetFlags(4'b0100);
      pushExp(32'h0000_0000, 4'b1100);
      doOp(32'h7777_7777, 32'h8888_8888, 5'b10101, 1'b1, 0, "adc_carry");
   endtask

   task automatic test_no_wf();
      presetFlags(4'b1111);
      pushExp(32'h5555_5555, 4'b1111);
      doOp(32'h1234_1234, 32'h4321_4321, 5'b10100, 1'b0, 0, "add_no_wf");
      checks++;
      if (aluFlags !== 4'b1111) begin
         errors++;
         $display("FAIL no_wf_flags_kept: ALU flags=%b want 1111", aluFlags);
      end
   endtask

   task automatic test_backpressure();
      pushExp(32'h5555_5555, 4'b0000);
      doOp(32'h1234_1234, 32'h4321_4321, 5'b10100, 1'b1, 5, "backpressure");
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic        wf;
      logic [35:0] r;
      for (int k = 0; k < 6; k++) begin
         a  = $urandom();
         b  = $urandom();
         wf = 1'($urandom_range(0, 1));
         r  = aluCalc(a, b, 5'b10100, 1'b0);
         pushExp(r[31:0], wf ? r[35:32] : aluFlags);
         doOp(a, b, 5'b10100, wf, k % 2, "back_to_back");
      end
   endtask

   task automatic test_wrap();
      logic [31:0] a, b;
      int n;
      for (int k = 0; k < 8; k++) begin
         a = $urandom();
         b = $urandom();
         n = 0;
         while (!sReqReady && n < 20) begin
            @(posedge Clock); #1;
            n++;
         end
         sReqA = a; sReqB = b; sReqValid = 1'b1;
         @(posedge Clock); #1;
         sReqValid = 1'b0;
         @(posedge Clock); #1;
         @(posedge Clock); #1;
         checks++;
         if (sRspValid !== 1'b1 || sRspData !== (a ^ b) || sRspFlags !== 4'b0101) begin
            errors++;
            $display("FAIL wrap_result%0d: RspValid=%b RspData=%h RspFlags=%b want 1 %h 0101",
                     k, sRspValid, sRspData, sRspFlags, a ^ b);
         end
         sRspReady = 1'b1;
         @(posedge Clock); #1;
         sRspReady = 1'b0;
         checks++;
         if (sOpCount !== 3'(k + 1)) begin
            errors++;
            $display("FAIL wrap_count%0d: OpCount=%0d want %0d", k, sOpCount, 3'(k + 1));
         end
      end
   endtask

   initial begin
      ReqValid = 1'b0; ReqA = '0; ReqB = '0; ReqFunSel = '0; ReqWF = 1'b0; RspReady = 1'b0;
      sReqValid = 1'b0; sReqA = '0; sReqB = '0; sRspReady = 1'b0;
      presetVld = 1'b1; presetVal = 4'b0000;
      test_reset();
      presetVld = 1'b0;
      test_reset_mid();
      test_add_flags();
      test_adc();
      test_no_wf();
      test_backpressure();
      test_back_to_back();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
